// File: rtl/hazard_stall_controller_pkg.sv
// Shared definitions for the hazard/stall controller.
// Holds the HAZ_STATE encodings, the x0 register constant and the default
// watchdog parameters used by the top level.
package hazard_stall_controller_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  // Writes to x0 are discarded, so a load into x0 never creates a hazard.
  localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 255;
  localparam int unsigned TIMEOUT_W_DEF      = 8;

  typedef enum logic [1:0] {
    HS_RUN    = 2'd0,
    HS_FREEZE = 2'd1,
    HS_ERROR  = 2'd2
  } haz_state_e;

endpackage

// File: rtl/hazard_stall_controller_load_use_detector.sv
// Load-use hazard detector: flags an ID instruction that reads the register
// a load in EX is about to write. Purely combinational.
// Ports:
//   id_rs1_i, id_rs2_i       source registers of the ID instruction
//   id_uses_rs1_i/rs2_i      the ID instruction really reads that source
//   ex_mem_read_i            EX instruction is a load
//   ex_reg_write_en_i        EX instruction writes the register file
//   ex_rd_i                  destination register of the EX instruction
//   load_use_o               stall required
module hazard_stall_controller_load_use_detector
  import hazard_stall_controller_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  id_uses_rs1_i,
  input  logic                  id_uses_rs2_i,
  input  logic                  ex_mem_read_i,
  input  logic                  ex_reg_write_en_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  output logic                  load_use_o
);

  logic rs1_hit_c;
  logic rs2_hit_c;

  assign rs1_hit_c  = id_uses_rs1_i & (id_rs1_i == ex_rd_i);
  assign rs2_hit_c  = id_uses_rs2_i & (id_rs2_i == ex_rd_i);
  assign load_use_o = ex_mem_read_i & ex_reg_write_en_i & (ex_rd_i != REG_X0)
                    & (rs1_hit_c | rs2_hit_c);

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing controller: merges memory busywait freezes, branch
// flushes and load-use stalls into prioritised hold/flush/bubble controls,
// latches branches that resolve during a freeze, and traps a memory that
// never releases busywait.
// Ports:
//   CLK, RESET                  clock, asynchronous active-high reset
//   ID_*/EX_*                   hazard inputs for the load-use detector
//   BRANCH_TAKEN                one-cycle branch-taken pulse
//   IMEM_BUSYWAIT/DMEM_BUSYWAIT memory busywaits
//   PC_HOLD, IF_ID_HOLD, IF_ID_FLUSH, ID_EX_BUBBLE, PIPE_FREEZE
//                               Mealy pipeline controls (0 while RESET)
//   MEM_TIMEOUT                 sticky watchdog error
//   HAZ_STATE                   RUN=0, FREEZE=1, ERROR=2
//   STALL_CYCLES, FLUSH_COUNT   performance counters, present only when
//                               HAZARD_PERF_CNT_EN is defined
module hazard_stall_controller
  import hazard_stall_controller_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int unsigned TIMEOUT_W      = TIMEOUT_W_DEF
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [REG_ADDR_W-1:0] ID_REG_READ_ADDR1,
  input  logic [REG_ADDR_W-1:0] ID_REG_READ_ADDR2,
  input  logic                  ID_USES_RS1,
  input  logic                  ID_USES_RS2,
  input  logic                  EX_MEM_READ,
  input  logic                  EX_REG_WRITE_EN,
  input  logic [REG_ADDR_W-1:0] EX_REG_WRITE_ADDR,
  input  logic                  BRANCH_TAKEN,
  input  logic                  IMEM_BUSYWAIT,
  input  logic                  DMEM_BUSYWAIT,
  output logic                  PC_HOLD,
  output logic                  IF_ID_HOLD,
  output logic                  IF_ID_FLUSH,
  output logic                  ID_EX_BUBBLE,
  output logic                  PIPE_FREEZE,
  output logic                  MEM_TIMEOUT,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0]           STALL_CYCLES,
  output logic [31:0]           FLUSH_COUNT,
`endif
  output logic [1:0]            HAZ_STATE
);

  localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMEOUT_W-1:0] WD_MAX  = '1;

  haz_state_e           state_q;
  logic                 branch_pend_q;
  logic [TIMEOUT_W-1:0] wd_cnt_q;
  logic                 mem_timeout_q;

  logic freeze_c;
  logic branch_c;
  logic load_use_c;
  logic pc_hold_c;
  logic if_id_hold_c;
  logic if_id_flush_c;
  logic id_ex_bubble_c;
  logic pipe_freeze_c;

  assign freeze_c = IMEM_BUSYWAIT | DMEM_BUSYWAIT;
  assign branch_c = BRANCH_TAKEN | branch_pend_q;

  hazard_stall_controller_load_use_detector u_load_use_detector (
    .id_rs1_i          (ID_REG_READ_ADDR1),
    .id_rs2_i          (ID_REG_READ_ADDR2),
    .id_uses_rs1_i     (ID_USES_RS1),
    .id_uses_rs2_i     (ID_USES_RS2),
    .ex_mem_read_i     (EX_MEM_READ),
    .ex_reg_write_en_i (EX_REG_WRITE_EN),
    .ex_rd_i           (EX_REG_WRITE_ADDR),
    .load_use_o        (load_use_c)
  );

  // Prioritised controls; FREEZE with busywait released follows RUN priority.
  always_comb begin
    pc_hold_c      = 1'b0;
    if_id_hold_c   = 1'b0;
    if_id_flush_c  = 1'b0;
    id_ex_bubble_c = 1'b0;
    pipe_freeze_c  = 1'b0;
    if (state_q == HS_ERROR || freeze_c) begin
      pc_hold_c     = 1'b1;
      if_id_hold_c  = 1'b1;
      pipe_freeze_c = 1'b1;
    end else if (branch_c) begin
      if_id_flush_c  = 1'b1;
      id_ex_bubble_c = 1'b1;
    end else if (load_use_c) begin
      pc_hold_c      = 1'b1;
      if_id_hold_c   = 1'b1;
      id_ex_bubble_c = 1'b1;
    end
  end

  // Controls are forced low for as long as reset is held.
  assign PC_HOLD      = pc_hold_c      & ~RESET;
  assign IF_ID_HOLD   = if_id_hold_c   & ~RESET;
  assign IF_ID_FLUSH  = if_id_flush_c  & ~RESET;
  assign ID_EX_BUBBLE = id_ex_bubble_c & ~RESET;
  assign PIPE_FREEZE  = pipe_freeze_c  & ~RESET;
  assign MEM_TIMEOUT  = mem_timeout_q;
  assign HAZ_STATE    = state_q;

  // State, watchdog and pending-branch register. The watchdog starts at 1 on
  // entry to FREEZE because the RUN cycle that saw busywait is the first
  // freeze cycle; the trap then fires at the end of freeze cycle TIMEOUT_CYCLES.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q       <= HS_RUN;
      branch_pend_q <= 1'b0;
      wd_cnt_q      <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        HS_RUN: begin
          if (freeze_c) begin
            state_q  <= HS_FREEZE;
            wd_cnt_q <= TIMEOUT_W'(1);
          end
        end
        HS_FREEZE: begin
          if (!freeze_c) begin
            state_q  <= HS_RUN;
            wd_cnt_q <= '0;
          end else if (wd_cnt_q == WD_LAST) begin
            state_q       <= HS_ERROR;
            mem_timeout_q <= 1'b1;
          end else if (wd_cnt_q != WD_MAX) begin
            wd_cnt_q <= wd_cnt_q + TIMEOUT_W'(1);
          end
        end
        HS_ERROR: begin
          state_q <= HS_ERROR;
        end
        default: begin
          state_q <= HS_RUN;
        end
      endcase

      if (state_q != HS_ERROR) begin
        if (freeze_c && BRANCH_TAKEN) begin
          branch_pend_q <= 1'b1;
        end else if (if_id_flush_c) begin
          branch_pend_q <= 1'b0;
        end
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] flush_count_q;

  // Free-running event counters, wrapping modulo 2^32.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (PC_HOLD) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
      if (IF_ID_FLUSH) begin
        flush_count_q <= flush_count_q + 32'd1;
      end
    end
  end

  assign STALL_CYCLES = stall_cycles_q;
  assign FLUSH_COUNT  = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench for hazard_stall_controller: directed cycles push their
// hand-computed expected controls, a negedge monitor pops and compares.
module tb_hazard_stall_controller;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [4:0] rs1, rs2, rd;
  logic       u1, u2, mr, we, br, ib, db;

  logic       PC_HOLD, IF_ID_HOLD, IF_ID_FLUSH, ID_EX_BUBBLE, PIPE_FREEZE, MEM_TIMEOUT;
  logic [1:0] HAZ_STATE;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] STALL_CYCLES, FLUSH_COUNT;
`endif

  always #5 CLK = ~CLK;

  hazard_stall_controller #(
    .TIMEOUT_CYCLES (4),
    .TIMEOUT_W      (8)
  ) dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .ID_REG_READ_ADDR1 (rs1),
    .ID_REG_READ_ADDR2 (rs2),
    .ID_USES_RS1       (u1),
    .ID_USES_RS2       (u2),
    .EX_MEM_READ       (mr),
    .EX_REG_WRITE_EN   (we),
    .EX_REG_WRITE_ADDR (rd),
    .BRANCH_TAKEN      (br),
    .IMEM_BUSYWAIT     (ib),
    .DMEM_BUSYWAIT     (db),
    .PC_HOLD           (PC_HOLD),
    .IF_ID_HOLD        (IF_ID_HOLD),
    .IF_ID_FLUSH       (IF_ID_FLUSH),
    .ID_EX_BUBBLE      (ID_EX_BUBBLE),
    .PIPE_FREEZE       (PIPE_FREEZE),
    .MEM_TIMEOUT       (MEM_TIMEOUT),
`ifdef HAZARD_PERF_CNT_EN
    .STALL_CYCLES      (STALL_CYCLES),
    .FLUSH_COUNT       (FLUSH_COUNT),
`endif
    .HAZ_STATE         (HAZ_STATE)
  );

  // ctl = {PC_HOLD, IF_ID_HOLD, IF_ID_FLUSH, ID_EX_BUBBLE, PIPE_FREEZE, MEM_TIMEOUT}
  typedef struct {
    string       nm;
    logic [5:0]  ctl;
    logic [1:0]  st;
    bit          perf;
    logic [31:0] stall;
    logic [31:0] flush;
  } exp_t;

  localparam logic [5:0] C_NONE  = 6'b000000;
  localparam logic [5:0] C_LU    = 6'b110100;
  localparam logic [5:0] C_FRZ   = 6'b110010;
  localparam logic [5:0] C_FLUSH = 6'b001100;
  localparam logic [5:0] C_ERR   = 6'b110011;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [5:0] mon_got;
  int         checks = 0;
  int         errors = 0;

  task automatic nxt();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr();
    rs1 = '0; rs2 = '0; rd = '0;
    u1 = 0; u2 = 0; mr = 0; we = 0; br = 0; ib = 0; db = 0;
  endtask

  task automatic set_lu(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] d,
                        input logic e1, input logic e2);
    mr = 1; we = 1; rs1 = a1; rs2 = a2; rd = d; u1 = e1; u2 = e2;
  endtask

  task automatic push(input string nm, input logic [5:0] ctl, input logic [1:0] st);
    exp_t e;
    e.nm = nm; e.ctl = ctl; e.st = st; e.perf = 0; e.stall = '0; e.flush = '0;
    sb.push_back(e);
  endtask

  task automatic push_perf(input string nm, input logic [5:0] ctl, input logic [1:0] st,
                           input logic [31:0] stall, input logic [31:0] flush);
    exp_t e;
    e.nm = nm; e.ctl = ctl; e.st = st; e.perf = 1; e.stall = stall; e.flush = flush;
    sb.push_back(e);
  endtask

  // Monitor: the DUT presents a control vector every cycle; compare mid-cycle.
  initial begin
    forever begin
      @(negedge CLK);
      if (sb.size() != 0) begin
        mon_e   = sb.pop_front();
        mon_got = {PC_HOLD, IF_ID_HOLD, IF_ID_FLUSH, ID_EX_BUBBLE, PIPE_FREEZE, MEM_TIMEOUT};
        checks++;
        if (mon_got !== mon_e.ctl || HAZ_STATE !== mon_e.st) begin
          errors++;
          $display("FAIL %s: got ctl=%b state=%0d, expected ctl=%b state=%0d",
                   mon_e.nm, mon_got, HAZ_STATE, mon_e.ctl, mon_e.st);
        end
`ifdef HAZARD_PERF_CNT_EN
        if (mon_e.perf) begin
          checks++;
          if (STALL_CYCLES !== mon_e.stall || FLUSH_COUNT !== mon_e.flush) begin
            errors++;
            $display("FAIL %s_perf: got stall=%0d flush=%0d, expected stall=%0d flush=%0d",
                     mon_e.nm, STALL_CYCLES, FLUSH_COUNT, mon_e.stall, mon_e.flush);
          end
        end
`endif
      end
    end
  end

  initial begin
    RESET = 1; clr();

    // Controls gated while reset is held, even with busywait and branch up.
    nxt(); RESET = 1; db = 1; br = 1;    push("reset_gate", C_NONE, 2'd0);
    nxt(); RESET = 0; clr();             push("idle", C_NONE, 2'd0);

    // Load-use stall and its non-stalling variants.
    nxt(); set_lu(5'd5, 5'd0, 5'd5, 1, 0); push("load_use", C_LU, 2'd0);
    nxt(); clr();                          push("lu_after", C_NONE, 2'd0);
    nxt(); set_lu(5'd0, 5'd0, 5'd0, 1, 0); push("x0_no_stall", C_NONE, 2'd0);
    nxt(); set_lu(5'd0, 5'd7, 5'd7, 0, 0); push("rs2_unused", C_NONE, 2'd0);
    nxt(); set_lu(5'd0, 5'd7, 5'd7, 0, 1); push("rs2_used", C_LU, 2'd0);

    // Branch during a three-cycle data-memory freeze.
    nxt(); clr(); db = 1; br = 1;          push("frz1_branch", C_FRZ, 2'd0);
    nxt(); br = 0;                         push("frz2", C_FRZ, 2'd1);
    nxt();                                 push("frz3", C_FRZ, 2'd1);
    nxt(); db = 0;                         push("release_flush", C_FLUSH, 2'd1);
    nxt();                                 push("post_release", C_NONE, 2'd0);

    // Branch and load-use together: flush wins.
    nxt(); set_lu(5'd5, 5'd0, 5'd5, 1, 0); br = 1; push("br_lu", C_FLUSH, 2'd0);
    nxt(); clr();                          push("idle2", C_NONE, 2'd0);

    // Freeze over load-use, then the stall on the release cycle.
    nxt(); set_lu(5'd9, 5'd0, 5'd9, 1, 0); ib = 1; push("frz_lu", C_FRZ, 2'd0);
    nxt(); ib = 0;                         push("release_lu", C_LU, 2'd1);
    nxt(); clr();                          push("idle3", C_NONE, 2'd0);

    // Watchdog: four consecutive freeze cycles trap into ERROR.
    nxt(); db = 1;                         push("wd1", C_FRZ, 2'd0);
    nxt();                                 push("wd2", C_FRZ, 2'd1);
    nxt();                                 push("wd3", C_FRZ, 2'd1);
    nxt();                                 push("wd4", C_FRZ, 2'd1);
    nxt();                                 push("error", C_ERR, 2'd2);
    nxt(); db = 0; br = 1;                 push("error_sticky", C_ERR, 2'd2);
    nxt(); br = 0;
    push_perf("error_hold", C_ERR, 2'd2, 32'd13, 32'd2);
    nxt(); RESET = 1;                      push("async_reset", C_NONE, 2'd0);
    nxt(); RESET = 0;
    push_perf("after_reset", C_NONE, 2'd0, 32'd0, 32'd0);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge CLK);
    @(posedge CLK);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending entries, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
